reg_file_mp: RTL and testbench
==============================

Name: reg_file_mp

Overview:
- Parametrised multi-port integer register file; successor of the single-write/dual-read 64-bit file in the core datapath.
- Generalised in data width, depth, read-port count and write-port count; x0 is hardwired to zero.
- Adds same-cycle write-to-read forwarding, per-port read enable with hold, and a sequential soft-clear engine.
- Sits between decode (read) and writeback (write) stages.

Parameters:
- XLEN, 64: data width in bits.
- NREG, 32: number of registers; power of two, at least 2.
- NRD, 2: number of read ports, 1 to 4.
- NWR, 1: number of write ports, 1 to 2.
- AW, $clog2(NREG): address width; derived, not to be overridden.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- r_en  in  NRD  per-port read enable.
- r_addr  in  NRD*AW  read addresses; port p occupies bits [p*AW +: AW].
- r_data  out  NRD*XLEN  registered read data; port p occupies bits [p*XLEN +: XLEN].
- w_en  in  NWR  per-port write enable.
- w_addr  in  NWR*AW  write addresses.
- w_data  in  NWR*XLEN  write data.
- clr_req  in  1  soft-clear request pulse.
- clr_busy  out  1  high while the soft-clear sequence runs.
- par_err  out  NRD  parity error flags; present only with the optional feature, otherwise driven 0.

Behaviour:
- Clock and reset: one clock, clk; reset rstn is asynchronous and active-low.
- Reset values:
  - All array entries 0.
  - r_data 0.
  - clr_busy 0.
  - par_err 0.
  - Clear FSM in IDLE with index 0.
- Writes:
  - An enabled write commits at the clk edge.
  - Writes to address 0 are discarded; entry 0 always reads as 0.
  - Two write ports to the same address in the same cycle: port NWR-1 (highest index) wins.
- Reads:
  - Latency is 1 cycle: r_data[p] updates at the edge after r_en[p]=1 is sampled.
  - When r_en[p]=0, r_data[p] holds its previous value.
- Forwarding (write-first):
  - If r_addr[p] equals an enabled nonzero w_addr in the same cycle, r_data[p] returns the new w_data.
  - Write-port priority for forwarding matches the commit priority.
  - r_addr=0 always returns 0, with no forwarding.
- Clear FSM:
  - States: IDLE and CLEAR.
  - IDLE to CLEAR when clr_req=1. clr_busy rises at the next edge; the index starts at 1.
  - In CLEAR, one entry is zeroed per cycle (index 1 to NREG-1), so the sequence takes NREG-1 cycles.
  - After the entry at index NREG-1 is zeroed, the FSM returns to IDLE and clr_busy falls.
  - clr_req while in CLEAR is ignored; the sequence does not restart.
- Writes during CLEAR:
  - A write to an address below the current index, or equal to it, commits normally. The clear has already passed these addresses, or the write overrides the clear in that cycle.
  - A write to an address above the index is dropped.
  - Forwarding follows the same rule.
- Reads during CLEAR: return the current array contents, with forwarding as above.
- Reset mid-operation: rstn low in any state returns the block to the reset values immediately.

Optional Feature:
- Macro: REGFILE_PARITY_EN.
- Enabled:
  - Each entry stores one extra even-parity bit, computed at write time over the written data.
  - The soft-clear writes parity 0.
  - On each enabled read, parity is recomputed over the read data. par_err[p] is a 1-cycle registered pulse aligned with r_data[p].
  - Forwarded data and address-0 reads never flag an error.
- Disabled:
  - No parity storage.
  - par_err tied to 0.

Decomposition:
- Shared package regfile_pkg holds:
  - XLEN_DEF=64 and NREG_DEF=32.
  - The clear-state enum: IDLE=1'b0, CLEAR=1'b1.
  - An even-parity function.
- One natural sub-module, regfile_clr_fsm: owns the state, the index counter and clr_busy, and outputs the clear write enable and clear write address.

Test Plan:
- Reset then read → all zeros:
  - Stimulus: assert rstn low, release it, then read addresses 5 and 31 with r_en=11.
  - Required response: one cycle later r_data is 0 and 0.
- Write then read, plus x0 → write value returned, x0 stays 0:
  - Stimulus: write 64'hDEAD_BEEF_0123_4567 to address 7; next cycle read address 7 on port 0.
  - Required response: r_data[0] = 64'hDEAD_BEEF_0123_4567 at the following edge.
  - Stimulus: write any value to address 0, then read address 0.
  - Required response: 0.
- Same-cycle write and read → forwarded value:
  - Stimulus: write 64'h55 to address 3 while port 1 reads address 3.
  - Required response: r_data[1] = 64'h55 at the next edge.
  - Stimulus: repeat with r_en[1]=0.
  - Required response: r_data[1] holds its previous value.
- Dual-write collision → highest port wins:
  - Stimulus: with NWR=2, write 64'h1 on port 0 and 64'h2 on port 1, both to address 9.
  - Required response: a read of address 9 returns 64'h2.
- Soft clear → all registers zeroed, then writes resume:
  - Stimulus: fill all 31 registers with nonzero data, then pulse clr_req.
  - Required response: clr_busy is high for exactly 31 cycles.
  - Stimulus: during the clear, write 64'hAA to address 2 at index 10.
  - Required response: that write is kept.
  - Stimulus: during the clear, write to address 20 at index 10.
  - Required response: that write is dropped.
  - Stimulus: after the clear, read address 20 and address 2.
  - Required response: 0 and 64'hAA.
- Parity error, with REGFILE_PARITY_EN → single-cycle flag:
  - Stimulus: force-flip one stored bit of entry 4, then read entry 4.
  - Required response: par_err[0] = 1 for exactly one cycle, aligned with r_data.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types, defaults and helpers for the multi-port integer register file.
// Parity storage is compiled in only when REGFILE_PARITY_EN is defined.
package regfile_pkg;

  localparam int XLEN_DEF = 64;
  localparam int NREG_DEF = 32;
  // Widest data word the parity helper accepts; narrower words are zero-extended.
  localparam int PAR_MAXW = 256;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

  // Even parity: the returned bit makes the total number of ones even.
  function automatic logic even_par(input logic [PAR_MAXW-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// Read/write/clear bus of the multi-port register file; decode/writeback side is
// the master, the register file is the slave.
interface reg_file_mp_if #(
  parameter int XLEN = 64,
  parameter int NREG = 32,
  parameter int NRD  = 2,
  parameter int NWR  = 1
) ();
  localparam int AW = $clog2(NREG);

  logic [NRD-1:0]      r_en;
  logic [NRD*AW-1:0]   r_addr;
  logic [NRD*XLEN-1:0] r_data;
  logic [NWR-1:0]      w_en;
  logic [NWR*AW-1:0]   w_addr;
  logic [NWR*XLEN-1:0] w_data;
  logic                clr_req;
  logic                clr_busy;
  logic [NRD-1:0]      par_err;

  modport master (
    output r_en, r_addr, w_en, w_addr, w_data, clr_req,
    input  r_data, clr_busy, par_err
  );

  modport slave (
    input  r_en, r_addr, w_en, w_addr, w_data, clr_req,
    output r_data, clr_busy, par_err
  );
endinterface

// File: rtl/regfile_clr_fsm.sv
// Soft-clear sequencer: walks entries 1..NREG-1, zeroing one per cycle, and
// reports the entry currently being cleared.
module regfile_clr_fsm
  import regfile_pkg::*;
#(
  parameter  int NREG = NREG_DEF,
  localparam int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          clr_req,
  output logic          clr_busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  clr_state_e    state_q;
  logic [AW-1:0] idx_q;

  // NOTE: state is updated with <= only, so every reader sees the pre-edge value.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      clr_busy <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (clr_req) begin
            state_q  <= CLEAR;
            idx_q    <= AW'(1);
            clr_busy <= 1'b1;
          end
        end
        CLEAR: begin
          // A new request here is ignored; the walk always runs to completion.
          if (idx_q == AW'(NREG - 1)) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            clr_busy <= 1'b0;
          end else begin
            idx_q <= idx_q + AW'(1);
          end
        end
        default: begin
          state_q  <= IDLE;
          idx_q    <= '0;
          clr_busy <= 1'b0;
        end
      endcase
    end
  end

  assign clr_we   = (state_q == CLEAR);
  assign clr_addr = idx_q;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port integer register file: x0 hardwired to zero, write-first forwarding,
// read-enable hold, soft clear; optional parity under REGFILE_PARITY_EN.
module reg_file_mp
  import regfile_pkg::*;
#(
  parameter  int XLEN = XLEN_DEF,
  parameter  int NREG = NREG_DEF,
  parameter  int NRD  = 2,
  parameter  int NWR  = 1,
  localparam int AW   = $clog2(NREG)
) (
  input logic            clk,
  input logic            rstn,
  reg_file_mp_if.slave   bus
);

  logic [XLEN-1:0]           mem_q [NREG];
  logic [NRD-1:0][XLEN-1:0]  rd_q, rd_d;
  logic [NRD-1:0][AW-1:0]    ra;
  logic [NWR-1:0][AW-1:0]    wa;
  logic [NWR-1:0][XLEN-1:0]  wd;
  logic [NWR-1:0]            w_ok;
  logic [NRD-1:0]            fwd_hit;
  logic                      clr_busy, clr_we;
  logic [AW-1:0]             clr_addr;

  assign ra = bus.r_addr;
  assign wa = bus.w_addr;
  assign wd = bus.w_data;

  regfile_clr_fsm #(.NREG(NREG)) u_clr (
    .clk      (clk),
    .rstn     (rstn),
    .clr_req  (bus.clr_req),
    .clr_busy (clr_busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  assign bus.clr_busy = clr_busy;

  // A write qualifies unless it targets x0 or an entry the clear has not reached yet.
  always_comb begin
    w_ok = '0;
    for (int k = 0; k < NWR; k++) begin
      w_ok[k] = bus.w_en[k] && (wa[k] != '0) && (!clr_we || (wa[k] <= clr_addr));
    end
  end

`ifdef REGFILE_PARITY_EN
  logic                  par_q [NREG];
  logic [NWR-1:0]        w_par;
  logic [NRD-1:0]        perr_d, perr_q;
  logic [PAR_MAXW-1:0]   ext_w, ext_r;

  always_comb begin
    w_par = '0;
    ext_w = '0;
    for (int k = 0; k < NWR; k++) begin
      ext_w            = '0;
      ext_w[XLEN-1:0]  = wd[k];
      w_par[k]         = even_par(ext_w);
    end
  end
`endif

  // NOTE: every variable gets a default at the top of always_comb so no latch is inferred.
  always_comb begin
    rd_d    = rd_q;
    fwd_hit = '0;
`ifdef REGFILE_PARITY_EN
    perr_d  = '0;
    ext_r   = '0;
`endif
    for (int p = 0; p < NRD; p++) begin
      if (bus.r_en[p]) begin
        if (ra[p] == '0) begin
          rd_d[p] = '0;
        end else begin
          rd_d[p] = mem_q[ra[p]];
          // Ascending scan: the highest-index matching port wins, as on commit.
          for (int k = 0; k < NWR; k++) begin
            if (w_ok[k] && (wa[k] == ra[p])) begin
              rd_d[p]    = wd[k];
              fwd_hit[p] = 1'b1;
            end
          end
`ifdef REGFILE_PARITY_EN
          ext_r           = '0;
          ext_r[XLEN-1:0] = mem_q[ra[p]];
          perr_d[p]       = !fwd_hit[p] && (even_par(ext_r) != par_q[ra[p]]);
`endif
        end
      end
    end
  end

  // NOTE: the array carries an async reset because reset must leave every entry at zero.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NREG; i++) begin
        mem_q[i] <= '0;
`ifdef REGFILE_PARITY_EN
        par_q[i] <= 1'b0;
`endif
      end
    end else begin
      // Clear first so a same-cycle write to the clear index overrides it.
      if (clr_we) begin
        mem_q[clr_addr] <= '0;
`ifdef REGFILE_PARITY_EN
        par_q[clr_addr] <= 1'b0;
`endif
      end
      for (int k = 0; k < NWR; k++) begin
        if (w_ok[k]) begin
          mem_q[wa[k]] <= wd[k];
`ifdef REGFILE_PARITY_EN
          par_q[wa[k]] <= w_par[k];
`endif
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_q <= '0;
    end else begin
      rd_q <= rd_d;
    end
  end

  assign bus.r_data = rd_q;

`ifdef REGFILE_PARITY_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perr_q <= '0;
    end else begin
      perr_q <= perr_d;
    end
  end

  assign bus.par_err = perr_q;
`else
  assign bus.par_err = '0;
`endif

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed self-checking bench for reg_file_mp (XLEN=64, NREG=32, NRD=2, NWR=2).
module tb_reg_file_mp;

  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int NWR  = 2;

  logic clk;
  logic rstn;
  int   checks;
  int   failures;

  reg_file_mp_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) bus ();

  reg_file_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    string       name;
    logic [1:0]  r_en;
    logic [4:0]  ra0, ra1;
    logic [1:0]  w_en;
    logic [4:0]  wa0;
    logic [63:0] wd0;
    logic [4:0]  wa1;
    logic [63:0] wd1;
    logic [63:0] e0, e1;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic idle();
    bus.r_en    = '0;
    bus.r_addr  = '0;
    bus.w_en    = '0;
    bus.w_addr  = '0;
    bus.w_data  = '0;
    bus.clr_req = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] fill(input int i);
    return 64'(i) * 64'h0101_0101_0101_0101;
  endfunction

  task automatic rd2(input logic [4:0] a0, input logic [4:0] a1);
    bus.r_en   = 2'b11;
    bus.r_addr = {a1, a0};
    step();
    idle();
  endtask

  int cnt;

  initial begin
    checks   = 0;
    failures = 0;
    idle();

    vecs[0]  = '{"rst_read",      2'b11, 5'd5,  5'd31, 2'b00, 5'd0,  64'h0,                  5'd0,  64'h0,  64'h0,                  64'h0};
    vecs[1]  = '{"wr7",           2'b00, 5'd0,  5'd0,  2'b01, 5'd7,  64'hDEAD_BEEF_0123_4567, 5'd0,  64'h0,  64'h0,                  64'h0};
    vecs[2]  = '{"rd7",           2'b01, 5'd7,  5'd0,  2'b00, 5'd0,  64'h0,                  5'd0,  64'h0,  64'hDEAD_BEEF_0123_4567, 64'h0};
    vecs[3]  = '{"wr_x0",         2'b00, 5'd0,  5'd0,  2'b01, 5'd0,  64'h123,                5'd0,  64'h0,  64'hDEAD_BEEF_0123_4567, 64'h0};
    vecs[4]  = '{"rd_x0",         2'b01, 5'd0,  5'd0,  2'b00, 5'd0,  64'h0,                  5'd0,  64'h0,  64'h0,                  64'h0};
    vecs[5]  = '{"fwd_p1",        2'b10, 5'd0,  5'd3,  2'b01, 5'd3,  64'h55,                 5'd0,  64'h0,  64'h0,                  64'h55};
    vecs[6]  = '{"hold_p1",       2'b00, 5'd0,  5'd3,  2'b01, 5'd3,  64'h77,                 5'd0,  64'h0,  64'h0,                  64'h55};
    vecs[7]  = '{"rd3_after",     2'b01, 5'd3,  5'd0,  2'b00, 5'd0,  64'h0,                  5'd0,  64'h0,  64'h77,                 64'h55};
    vecs[8]  = '{"collide_fwd",   2'b11, 5'd9,  5'd9,  2'b11, 5'd9,  64'h1,                  5'd9,  64'h2,  64'h2,                  64'h2};
    vecs[9]  = '{"collide_rd",    2'b11, 5'd9,  5'd7,  2'b00, 5'd0,  64'h0,                  5'd0,  64'h0,  64'h2,                  64'hDEAD_BEEF_0123_4567};
    vecs[10] = '{"x0_nofwd",      2'b11, 5'd0,  5'd10, 2'b11, 5'd10, 64'hA,                  5'd0,  64'hFF, 64'h0,                  64'hA};

    // Reset
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_r_data", bus.r_data[63:0], 64'h0);
    check("rst_busy", 64'(bus.clr_busy), 64'h0);
    rstn = 1'b1;
    step();

    // Table-driven single-cycle vectors
    for (int i = 0; i < 11; i++) begin
      bus.r_en   = vecs[i].r_en;
      bus.r_addr = {vecs[i].ra1, vecs[i].ra0};
      bus.w_en   = vecs[i].w_en;
      bus.w_addr = {vecs[i].wa1, vecs[i].wa0};
      bus.w_data = {vecs[i].wd1, vecs[i].wd0};
      step();
      idle();
      check({vecs[i].name, "_p0"}, bus.r_data[63:0], vecs[i].e0);
      check({vecs[i].name, "_p1"}, bus.r_data[127:64], vecs[i].e1);
      check({vecs[i].name, "_perr"}, 64'(bus.par_err), 64'h0);
    end

    // Fill every register with nonzero data, two per cycle
    for (int i = 1; i < NREG; i += 2) begin
      bus.w_en   = (i + 1 < NREG) ? 2'b11 : 2'b01;
      bus.w_addr = {5'(i + 1), 5'(i)};
      bus.w_data = {fill(i + 1), fill(i)};
      step();
    end
    idle();
    rd2(5'd20, 5'd31);
    check("fill_20", bus.r_data[63:0], fill(20));
    check("fill_31", bus.r_data[127:64], fill(31));

    // Soft clear with a kept write, a dropped write and an ignored re-request
    bus.clr_req = 1'b1;
    step();
    idle();
    cnt = 0;
    while (bus.clr_busy && cnt < 100) begin
      cnt++;
      if (cnt == 5) bus.clr_req = 1'b1;
      if (cnt == 10) begin
        bus.w_en   = 2'b11;
        bus.w_addr = {5'd20, 5'd2};
        bus.w_data = {64'hBB, 64'hAA};
        bus.r_en   = 2'b11;
        bus.r_addr = {5'd2, 5'd20};
      end
      step();
      idle();
      if (cnt == 10) begin
        check("clr_rd20_nofwd", bus.r_data[63:0], fill(20));
        check("clr_rd2_fwd", bus.r_data[127:64], 64'hAA);
      end
    end
    check("clr_busy_cycles", 64'(cnt), 64'd31);
    rd2(5'd20, 5'd2);
    check("post_clr_20", bus.r_data[63:0], 64'h0);
    check("post_clr_2", bus.r_data[127:64], 64'hAA);
    rd2(5'd31, 5'd1);
    check("post_clr_31", bus.r_data[63:0], 64'h0);
    check("post_clr_1", bus.r_data[127:64], 64'h0);

    // Reset in the middle of a clear
    bus.w_en   = 2'b01;
    bus.w_addr = {5'd0, 5'd6};
    bus.w_data = {64'h0, 64'h66};
    step();
    idle();
    bus.r_en    = 2'b01;
    bus.r_addr  = {5'd0, 5'd6};
    bus.clr_req = 1'b1;
    step();
    idle();
    check("midrst_rd6", bus.r_data[63:0], 64'h66);
    check("midrst_busy_on", 64'(bus.clr_busy), 64'h1);
    step();
    step();
    rstn = 1'b0;
    #1;
    check("midrst_busy_off", 64'(bus.clr_busy), 64'h0);
    check("midrst_r_data", bus.r_data[63:0], 64'h0);
    #2;
    rstn = 1'b1;
    step();
    rd2(5'd6, 5'd2);
    check("midrst_entry6", bus.r_data[63:0], 64'h0);
    check("midrst_entry2", bus.r_data[127:64], 64'h0);
    check("midrst_idle", 64'(bus.clr_busy), 64'h0);

`ifdef REGFILE_PARITY_EN
    // Corrupt one stored bit and expect a single-cycle flag aligned with the data
    bus.w_en   = 2'b01;
    bus.w_addr = {5'd0, 5'd4};
    bus.w_data = {64'h0, 64'hF0F0_0000_1234_0001};
    step();
    idle();
    dut.mem_q[4] = 64'hF0F0_0000_1234_0000;
    bus.r_en   = 2'b01;
    bus.r_addr = {5'd0, 5'd4};
    step();
    idle();
    check("par_data", bus.r_data[63:0], 64'hF0F0_0000_1234_0000);
    check("par_err_set", 64'(bus.par_err), 64'h1);
    bus.r_en   = 2'b01;
    bus.r_addr = {5'd0, 5'd5};
    step();
    idle();
    check("par_err_clear", 64'(bus.par_err), 64'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
